// File: rtl/hi_xcorr_sched.sv
// hi_xcorr_sched: carrier settle / correlator measurement scheduler that streams I/Q reports to the ARM over SSP.
// Define HI_XCORR_SCHED_OVF_EN to enable the sticky overflow flag; otherwise overflow is tied low.

module hi_xcorr_sched #(
    parameter int SETTLE_CYCLES  = 256,
    parameter int WINDOW_REPORTS = 16,
    parameter int SSP_DIV        = 4
) (
    input  logic       ck_1356meg,
    input  logic       rst_n,
    input  logic       start,
    input  logic       snoop,
    input  logic       corr_valid,
    input  logic [7:0] corr_i,
    input  logic [7:0] corr_q,
    output logic       pwr_hi_en,
    output logic       corr_clr,
    output logic       ssp_clk,
    output logic       ssp_frame,
    output logic       ssp_din,
    output logic       busy,
    output logic       overflow
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int RW = $clog2(WINDOW_REPORTS + 1);
    localparam int DW = (SSP_DIV > 2) ? $clog2(SSP_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DRAIN} state_t;

    state_t        state_q, state_d;
    logic          snoop_l_q, snoop_l_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [15:0]   fifo_q [4];
    logic [15:0]   fifo_d [4];
    logic [1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]    fifo_cnt_q, fifo_cnt_d;
    logic          ser_busy_q, ser_busy_d;
    logic [15:0]   shreg_q, shreg_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          pwr_q, pwr_d, clr_q, clr_d, busy_q, busy_d;
    logic          sclk_q, sclk_d, sfrm_q, sfrm_d, sdin_q, sdin_d;
    logic          accept, ser_last, pop, push;

    // The serializer may reload during the final cycle of bit 0 so words stream with no gap.
    assign accept   = (state_q == MEASURE) && corr_valid && !clr_q;
    assign ser_last = ser_busy_q && (bit_idx_q == 4'd0) && (div_cnt_q == DW'(SSP_DIV - 1));
    assign pop      = (!ser_busy_q || ser_last) && (fifo_cnt_q != 3'd0);
    assign push     = accept && ((fifo_cnt_q != 3'd4) || pop);

    always_comb begin
        state_d      = state_q;
        snoop_l_d    = snoop_l_q;
        settle_cnt_d = settle_cnt_q;
        rpt_cnt_d    = rpt_cnt_q;
        case (state_q)
            IDLE: if (start) begin
                state_d      = SETTLE;
                snoop_l_d    = snoop;
                settle_cnt_d = '0;
                rpt_cnt_d    = '0;
            end
            SETTLE: begin
                if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) state_d = MEASURE;
                else settle_cnt_d = settle_cnt_q + SW'(1);
            end
            MEASURE: if (accept) begin
                rpt_cnt_d = rpt_cnt_q + RW'(1);
                if (rpt_cnt_q == RW'(WINDOW_REPORTS - 1)) state_d = DRAIN;
            end
            DRAIN: if ((fifo_cnt_q == 3'd0) && !ser_busy_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {corr_i, corr_q};
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_comb begin
        ser_busy_d = ser_busy_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        div_cnt_d  = div_cnt_q;
        if (pop) begin
            ser_busy_d = 1'b1;
            shreg_d    = fifo_q[rd_ptr_q];
            bit_idx_d  = 4'd15;
            div_cnt_d  = '0;
        end else if (ser_busy_q) begin
            if (div_cnt_q == DW'(SSP_DIV - 1)) begin
                div_cnt_d = '0;
                shreg_d   = {shreg_q[14:0], 1'b0};
                if (bit_idx_q == 4'd0) ser_busy_d = 1'b0;
                else bit_idx_d = bit_idx_q - 4'd1;
            end else begin
                div_cnt_d = div_cnt_q + DW'(1);
            end
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_comb begin
        pwr_d  = ((state_d == SETTLE) || (state_d == MEASURE)) && !snoop_l_d;
        clr_d  = (state_q == SETTLE) && (state_d == MEASURE);
        busy_d = (state_d != IDLE);
        sdin_d = ser_busy_d && shreg_d[15];
        sclk_d = ser_busy_d && (div_cnt_d >= DW'(SSP_DIV / 2));
        sfrm_d = ser_busy_d && ((bit_idx_d == 4'd15) || (bit_idx_d == 4'd7));
    end

    always_ff @(posedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            snoop_l_q    <= 1'b0;
            settle_cnt_q <= '0;
            rpt_cnt_q    <= '0;
            for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            ser_busy_q   <= 1'b0;
            shreg_q      <= '0;
            bit_idx_q    <= '0;
            div_cnt_q    <= '0;
            pwr_q        <= 1'b0;
            clr_q        <= 1'b0;
            busy_q       <= 1'b0;
            sclk_q       <= 1'b0;
            sfrm_q       <= 1'b0;
            sdin_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            snoop_l_q    <= snoop_l_d;
            settle_cnt_q <= settle_cnt_d;
            rpt_cnt_q    <= rpt_cnt_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            ser_busy_q   <= ser_busy_d;
            shreg_q      <= shreg_d;
            bit_idx_q    <= bit_idx_d;
            div_cnt_q    <= div_cnt_d;
            pwr_q        <= pwr_d;
            clr_q        <= clr_d;
            busy_q       <= busy_d;
            sclk_q       <= sclk_d;
            sfrm_q       <= sfrm_d;
            sdin_q       <= sdin_d;
        end
    end

    assign pwr_hi_en = pwr_q;
    assign corr_clr  = clr_q;
    assign busy      = busy_q;
    assign ssp_clk   = sclk_q;
    assign ssp_frame = sfrm_q;
    assign ssp_din   = sdin_q;

`ifdef HI_XCORR_SCHED_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky until the next accepted start; only a report that could not enter the FIFO sets it.
    always_comb begin
        ovf_d = ovf_q;
        if ((state_q == IDLE) && start) ovf_d = 1'b0;
        else if (accept && !push) ovf_d = 1'b1;
    end

    always_ff @(posedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else ovf_q <= ovf_d;
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule
